// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and request/entry types for the writeback arbiter
package wb_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int ADDRESS_WIDTH = 3;
  localparam int RAM_DEPTH     = 1 << ADDRESS_WIDTH;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  // valid is cleared when a younger load targets the same register
  typedef struct packed {
    logic    valid;
    wb_req_t req;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular ALU result buffer with squash-by-address
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  wb_req_t                  push_req_i,
  input  logic                     pop_i,
  input  logic                     squash_i,
  input  logic [ADDRESS_WIDTH-1:0] squash_addr_i,
  output wb_entry_t                head_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [RAM_DEPTH-1:0]     valid_mask_o
);

  wb_entry_t        entry_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // squash first, then push/pop; a pushed slot is never occupied, so the new entry is never squashed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && entry_q[i].req.addr == squash_addr_i) entry_q[i].valid <= 1'b0;
      end
      if (push_i) entry_q[wr_ptr_q] <= '{valid: 1'b1, req: push_req_i};
      if (pop_i) entry_q[rd_ptr_q].valid <= 1'b0;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // popped slots are invalidated, so only live queued writes contribute to the mask
  always_comb begin
    valid_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_q[i].valid) valid_mask_o[entry_q[i].req.addr] = 1'b1;
    end
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - load-priority writeback arbiter owning the register file write port (option: WB_BYPASS_EN)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     write_en,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [RAM_DEPTH-1:0]     pending_mask,
  output logic [CNT_W-1:0]         fifo_count
);

  wb_entry_t                head;
  logic [CNT_W-1:0]         count;
  logic [RAM_DEPTH-1:0]     fifo_mask;
  logic                     fifo_nonempty;
  logic                     bypass;
  logic                     push;
  logic                     pop;
  logic                     write_en_q, write_en_d;
  logic [ADDRESS_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;

  assign fifo_nonempty = (count != '0);
  // ready depends only on registered occupancy; a same-cycle pop gives no credit
  assign alu_ready     = (count != CNT_W'(FIFO_DEPTH));

`ifdef WB_BYPASS_EN
  assign bypass = !fifo_nonempty && !mem_valid && alu_valid;
`else
  assign bypass = 1'b0;
`endif

  // loads own the output whenever present; the FIFO drains (valid or squashed) only in idle load cycles
  assign push = alu_valid && alu_ready && !bypass;
  assign pop  = !mem_valid && fifo_nonempty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_req_i   ('{addr: alu_addr, data: alu_data}),
    .pop_i        (pop),
    .squash_i     (mem_valid),
    .squash_addr_i(mem_addr),
    .head_o       (head),
    .count_o      (count),
    .valid_mask_o (fifo_mask)
  );

  // select next register file write: load, bypassed ALU, live FIFO head, or nothing
  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (mem_valid) begin
      write_en_d   = 1'b1;
      write_addr_d = mem_addr;
      write_data_d = mem_data;
    end else if (bypass) begin
      write_en_d   = 1'b1;
      write_addr_d = alu_addr;
      write_data_d = alu_data;
    end else if (fifo_nonempty && head.valid) begin
      write_en_d   = 1'b1;
      write_addr_d = head.req.addr;
      write_data_d = head.req.data;
    end
  end

  // registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en     = write_en_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign fifo_count   = count;
  assign pending_mask = fifo_mask | ({{(RAM_DEPTH-1){1'b0}}, write_en_q} << write_addr_q);

endmodule
